// File: rtl/frame_gen.sv
// Packet-framing beat source: turns a start/len request into a head/valid/tail
// beat stream with hold bubbles and a fixed idle gap after every packet.
module frame_gen #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             hold,
  output logic             ready,
  output logic             head,
  output logic             tail,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int unsigned GCNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   remain_q;
  logic               first_q;
  logic [GCNT_W-1:0]  gcnt_q;
  logic               head_q, tail_q, valid_q, err_q;
  logic [CNT_W-1:0]   pkt_count_q;

  logic [LEN_W-1:0]   beat_remain;
  logic               beat_first;
  logic               do_send;

  // The accepting edge already emits a beat, so it sources length/first from the request.
  always_comb begin
    beat_remain = remain_q;
    beat_first  = first_q;
    do_send     = 1'b0;
    if (state_q == S_IDLE) begin
      beat_remain = len;
      beat_first  = 1'b1;
      do_send     = start && (len != '0);
    end else if (state_q == S_SEND) begin
      do_send     = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remain_q    <= '0;
      first_q     <= 1'b0;
      gcnt_q      <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == S_IDLE && start && len == '0) begin
        err_q <= 1'b1;
      end

      if (do_send) begin
        if (hold) begin
          remain_q <= beat_remain;
          first_q  <= beat_first;
          state_q  <= S_SEND;
        end else begin
          valid_q <= 1'b1;
          head_q  <= beat_first;
          tail_q  <= (beat_remain == LEN_W'(1));
          if (beat_remain == LEN_W'(1)) begin
            pkt_count_q <= pkt_count_q + CNT_W'(1);
            remain_q    <= '0;
            first_q     <= 1'b0;
            gcnt_q      <= GCNT_W'(GAP);
            state_q     <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            remain_q <= beat_remain - LEN_W'(1);
            first_q  <= 1'b0;
            state_q  <= S_SEND;
          end
        end
      end else if (state_q == S_GAP) begin
        gcnt_q <= gcnt_q - GCNT_W'(1);
        if (gcnt_q == GCNT_W'(1)) begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign head      = head_q;
  assign tail      = tail_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_frame_gen.sv
// Scoreboard bench for frame_gen: one instance with the default gap, one with
// a zero gap; beat monitors pop expected {head,tail} pairs on every valid beat.
module tb_frame_gen;

  logic       clock;
  logic       rst2, st2, hold2, rdy2, head2, tail2, valid2, err2;
  logic [3:0] len2;
  logic [7:0] cnt2;
  logic       rst0, st0, hold0, rdy0, head0, tail0, valid0, err0;
  logic [3:0] len0;
  logic [7:0] cnt0;

  int errors = 0;
  int checks = 0;

  logic [1:0] q2[$];
  logic [1:0] q0[$];

  frame_gen #(.LEN_W(4), .GAP(2), .CNT_W(8)) dut2 (
    .clock(clock), .reset(rst2), .start(st2), .len(len2), .hold(hold2),
    .ready(rdy2), .head(head2), .tail(tail2), .valid(valid2), .err(err2),
    .pkt_count(cnt2)
  );

  frame_gen #(.LEN_W(4), .GAP(0), .CNT_W(8)) dut0 (
    .clock(clock), .reset(rst0), .start(st0), .len(len0), .hold(hold0),
    .ready(rdy0), .head(head0), .tail(tail0), .valid(valid0), .err(err0),
    .pkt_count(cnt0)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive2(input logic s, input logic [3:0] l, input logic h);
    st2 = s; len2 = l; hold2 = h;
    @(posedge clock); #1;
  endtask

  task automatic drive0(input logic s, input logic [3:0] l, input logic h);
    st0 = s; len0 = l; hold0 = h;
    @(posedge clock); #1;
  endtask

  initial begin
    int hv[6];
    int ev[6];
    int vh[8];
    clock = 1'b0;
    rst2 = 1'b0; rst0 = 1'b0;
    st2 = 1'b0; len2 = '0; hold2 = 1'b0;
    st0 = 1'b0; len0 = '0; hold0 = 1'b0;
    #1 rst2 = 1'b1; rst0 = 1'b1;
    #2;
    chk("rst_valid", int'(valid2), 0);
    chk("rst_head_tail", int'({head2, tail2}), 0);
    chk("rst_err", int'(err2), 0);
    chk("rst_ready", int'(rdy2), 1);
    chk("rst_count", int'(cnt2), 0);
    chk("rst0_ready", int'(rdy0), 1);
    @(posedge clock); @(posedge clock); #1;
    rst2 = 1'b0; rst0 = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (!rst2) begin
          if (valid2) begin
            if (q2.size() == 0) chk("g2_unexpected_beat", 1, 0);
            else chk("g2_beat_head_tail", int'({head2, tail2}), int'(q2.pop_front()));
          end else if (head2 || tail2) begin
            chk("g2_marker_without_valid", int'({head2, tail2}), 0);
          end
        end
      end
      forever begin
        @(negedge clock);
        if (!rst0) begin
          if (valid0) begin
            if (q0.size() == 0) chk("g0_unexpected_beat", 1, 0);
            else chk("g0_beat_head_tail", int'({head0, tail0}), int'(q0.pop_front()));
          end else if (head0 || tail0) begin
            chk("g0_marker_without_valid", int'({head0, tail0}), 0);
          end
        end
      end
    join_none

    // three-beat packet, no holds
    q2.push_back(2'b10); q2.push_back(2'b00); q2.push_back(2'b01);
    drive2(1'b1, 4'd3, 1'b0);
    chk("p3_b1_valid", int'(valid2), 1);
    chk("p3_b1_ready", int'(rdy2), 0);
    drive2(1'b0, 4'd0, 1'b0);
    chk("p3_b2_valid", int'(valid2), 1);
    chk("p3_b2_count", int'(cnt2), 0);
    drive2(1'b0, 4'd0, 1'b0);
    chk("p3_b3_valid", int'(valid2), 1);
    chk("p3_tail_count", int'(cnt2), 1);
    chk("p3_b3_ready", int'(rdy2), 0);
    drive2(1'b0, 4'd0, 1'b0);
    chk("p3_gap1_valid", int'(valid2), 0);
    chk("p3_gap1_ready", int'(rdy2), 0);
    drive2(1'b0, 4'd0, 1'b0);
    chk("p3_gap2_valid", int'(valid2), 0);

    // single-beat packet
    q2.push_back(2'b11);
    drive2(1'b1, 4'd1, 1'b0);
    chk("p1_valid", int'(valid2), 1);
    chk("p1_count", int'(cnt2), 2);
    drive2(1'b0, 4'd0, 1'b0);
    chk("p1_gap_valid", int'(valid2), 0);
    drive2(1'b0, 4'd0, 1'b0);

    // four beats with two hold bubbles
    hv = '{0, 1, 1, 0, 0, 0};
    ev = '{1, 0, 0, 1, 1, 1};
    q2.push_back(2'b10); q2.push_back(2'b00); q2.push_back(2'b00); q2.push_back(2'b01);
    for (int i = 0; i < 6; i++) begin
      drive2(i == 0, (i == 0) ? 4'd4 : 4'd0, hv[i] != 0);
      chk($sformatf("hold_valid_%0d", i), int'(valid2), ev[i]);
    end
    chk("hold_count", int'(cnt2), 3);
    drive2(1'b0, 4'd0, 1'b0);
    drive2(1'b0, 4'd0, 1'b0);

    // start held high, len=2, gap of two
    vh = '{1, 1, 0, 0, 1, 1, 0, 0};
    for (int p = 0; p < 2; p++) begin
      q2.push_back(2'b10); q2.push_back(2'b01);
    end
    for (int i = 0; i < 8; i++) begin
      drive2(1'b1, 4'd2, 1'b0);
      chk($sformatf("held_g2_valid_%0d", i), int'(valid2), vh[i]);
    end
    chk("held_g2_count", int'(cnt2), 5);

    // zero-length request
    drive2(1'b1, 4'd0, 1'b0);
    chk("zero_err", int'(err2), 1);
    chk("zero_valid", int'(valid2), 0);
    chk("zero_ready", int'(rdy2), 1);
    chk("zero_count", int'(cnt2), 5);
    drive2(1'b0, 4'd0, 1'b0);
    chk("zero_err_clear", int'(err2), 0);
    chk("zero_ready_after", int'(rdy2), 1);

    // reset during beat 2 of a five-beat packet
    q2.push_back(2'b10);
    drive2(1'b1, 4'd5, 1'b0);
    chk("rstmid_b1_valid", int'(valid2), 1);
    drive2(1'b0, 4'd0, 1'b0);
    chk("rstmid_b2_valid", int'(valid2), 1);
    #1 rst2 = 1'b1;
    #1;
    chk("rstmid_valid", int'(valid2), 0);
    chk("rstmid_head_tail", int'({head2, tail2}), 0);
    chk("rstmid_count", int'(cnt2), 0);
    chk("rstmid_ready", int'(rdy2), 1);
    @(posedge clock); #1;
    rst2 = 1'b0;
    q2.push_back(2'b10); q2.push_back(2'b01);
    drive2(1'b1, 4'd2, 1'b0);
    chk("post_rst_b1_valid", int'(valid2), 1);
    drive2(1'b0, 4'd0, 1'b0);
    chk("post_rst_b2_valid", int'(valid2), 1);
    chk("post_rst_count", int'(cnt2), 1);
    drive2(1'b0, 4'd0, 1'b0);
    drive2(1'b0, 4'd0, 1'b0);

    // zero gap: back-to-back len=2 packets
    for (int p = 0; p < 3; p++) begin
      q0.push_back(2'b10); q0.push_back(2'b01);
    end
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 4'd2, 1'b0);
      chk($sformatf("held_g0_valid_%0d", i), int'(valid0), 1);
    end
    chk("held_g0_count", int'(cnt0), 3);

    // counter wrap via one-beat packets every cycle
    for (int i = 0; i < 252; i++) begin
      q0.push_back(2'b11);
      drive0(1'b1, 4'd1, 1'b0);
    end
    chk("wrap_count_255", int'(cnt0), 255);
    q0.push_back(2'b11);
    drive0(1'b1, 4'd1, 1'b0);
    chk("wrap_count_0", int'(cnt0), 0);
    drive0(1'b0, 4'd0, 1'b0);
    chk("wrap_idle_valid", int'(valid0), 0);

    drive2(1'b0, 4'd0, 1'b0);
    drive0(1'b0, 4'd0, 1'b0);
    chk("g2_queue_drained", q2.size(), 0);
    chk("g0_queue_drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_gen.md
# frame_gen

Packet-framing generator that drives the `head`/`tail`/`valid` beat stream consumed by the framing `fsm` block. A packet request arrives on a start/ready handshake carrying a beat count. The block emits that many valid beats, with `head` on the first beat and `tail` on the last. Bubbles are inserted whenever `hold` is asserted, and a programmable idle gap follows every packet. It replaces hand-written stimulus sequences with a cycle-exact, reusable source stage.

## Interface
- `LEN_W`, 4: width of `len`; packets are 1..2^LEN_W-1 beats long.
- `GAP`, 2: minimum number of valid-low cycles between a tail beat and the next head beat; legal range 0..255.
- `CNT_W`, 8: width of `pkt_count`.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: packet request; accepted at a rising edge where `ready`=1.
- `len` in LEN_W: beat count; sampled with `start`.
- `hold` in 1: stall request; sampled every edge while sending.
- `ready` out 1: high only in IDLE; decoded combinationally from the state register.
- `head` out 1: registered; first beat of a packet.
- `tail` out 1: registered; last beat of a packet.
- `valid` out 1: registered; beat present.
- `err` out 1: registered; one-cycle pulse when a zero-length request is accepted.
- `pkt_count` out CNT_W: registered count of completed packets; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, SEND, GAP. Internal registers:
  - `remain` (LEN_W bits): beats still to emit.
  - `first` (1 bit): next beat is the head beat.
  - `gcnt` (8 bits): gap cycles still to wait.
- Reset values: state=IDLE, `head`=`tail`=`valid`=`err`=0, `pkt_count`=0, `ready`=1.
- IDLE, edge with `start`=1 and `len`≠0:
  - Latch `remain`=`len` and set `first`=1.
  - Evaluate the SEND beat rule in the same edge: the first beat is emitted at the accepting edge unless `hold`=1.
  - Go to SEND.
- IDLE, edge with `start`=1 and `len`=0: `err`=1 for one cycle; stay in IDLE; no beat emitted; `pkt_count` unchanged.
- IDLE, edge with `start`=0: beat outputs 0, `err`=0.
- SEND beat rule, applied at each edge:
  - `hold`=1: `valid`=`head`=`tail`=0; `remain` and `first` unchanged (bubble).
  - `hold`=0: `valid`=1, `head`=`first`, `tail`=(`remain`==1).
  - After a beat: `remain` decrements and `first` clears.
- Tail beat edge:
  - `pkt_count` increments; wraps from all-ones to 0.
  - If `GAP`=0, go to IDLE. Otherwise go to GAP with `gcnt`=`GAP`.
- GAP state, each edge:
  - Beat outputs 0.
  - `gcnt` decrements; on the edge where `gcnt` reaches 0, go to IDLE.
- A one-beat packet asserts `head`, `tail` and `valid` together for one cycle.
- `start` and `len` are ignored outside IDLE; a request is never queued.
- `head`/`tail` are never high while `valid` is low.

## Timing
- Latency: a request accepted at edge k with `hold`=0 shows head beat outputs from edge k until edge k+1.
- An N-beat packet with no holds occupies the outputs for N consecutive cycles after the accepting edge.
- Each `hold`=1 edge during SEND adds exactly one bubble cycle.
- Minimum spacing with `start` held high: tail beat, then exactly `GAP` valid-low cycles, then the next head beat.
- `ready` is low from the accepting edge through the end of the GAP state.
- Reset asserted mid-packet, on any cycle:
  - Outputs clear immediately (asynchronously); no partial tail is emitted.
  - `pkt_count`=0.
  - After release, the first usable accept is the first rising edge with `start`=1.

## Test plan
- Defaults (`GAP`=2), reset release, `start`=1 with `len`=3 for one edge, `hold`=0:
  - Three beats: `valid`=1,1,1; `head`=1,0,0; `tail`=0,0,1.
  - `pkt_count` 0→1 on the tail edge.
  - `ready` low for 5 cycles.
- `len`=1 → a single cycle with `head`=`tail`=`valid`=1; `pkt_count` increments by 1.
- `len`=4, `hold`=1 on the second and third SEND edges → `valid` pattern 1,0,0,1,1,1; `head` only on the first beat; `tail` only on the last.
- `start` held high with `len`=2, for `GAP`=2 and then for `GAP`=0:
  - `GAP`=2: `valid` pattern 1,1,0,0,1,1,0,0,…
  - `GAP`=0: head beat immediately follows tail beat; `valid` continuously 1.
- `len`=0 with `start`=1 → `err` pulses high for exactly 1 cycle; `valid` stays 0; `ready` stays 1; `pkt_count` unchanged.
- Reset mid-packet and counter wrap:
  - Reset asserted during beat 2 of `len`=5 → outputs 0 immediately and `pkt_count`=0.
  - After release, a `len`=2 packet runs normally.
  - Separately, 256 packets with `CNT_W`=8 → `pkt_count` wraps to 0.
